// File: rtl/seg_scan_pkg.sv
// Shared types and constants for the seven-segment scan driver.
package seg_scan_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      BLANK = 2'd1,
      DRIVE = 2'd2
   } state_e;

   localparam int unsigned MAX_DIGITS = 8;

   localparam int unsigned SEG_A  = 0;
   localparam int unsigned SEG_B  = 1;
   localparam int unsigned SEG_C  = 2;
   localparam int unsigned SEG_D  = 3;
   localparam int unsigned SEG_E  = 4;
   localparam int unsigned SEG_F  = 5;
   localparam int unsigned SEG_G  = 6;
   localparam int unsigned SEG_DP = 7;

   localparam logic [3:0] BRIGHT_FULL = 4'hF;

   // Pin level that turns every segment / digit off for a given polarity.
   function automatic logic [7:0] seg_off(input bit active_low);
      return {8{active_low}};
   endfunction

   function automatic logic [MAX_DIGITS-1:0] dig_off(input bit active_low);
      return {MAX_DIGITS{active_low}};
   endfunction

endpackage

// File: rtl/seg_scan_driver_if.sv
// Pattern/control inputs and pin outputs of the scan driver.
interface seg_scan_driver_if #(
   parameter int unsigned NUM_DIGITS = 4
);
   logic                      enable;
   logic [8*NUM_DIGITS-1:0]   seg_in;
   logic [3:0]                brightness;
   logic [7:0]                seg_out;
   logic [NUM_DIGITS-1:0]     dig_out;
   logic                      frame_tick;

   modport master (
      output enable, seg_in, brightness,
      input  seg_out, dig_out, frame_tick
   );

   modport slave (
      input  enable, seg_in, brightness,
      output seg_out, dig_out, frame_tick
   );
endinterface

// File: rtl/seg_scan_pwm.sv
// Brightness PWM: 4-bit counter cleared on DRIVE entry, compared against brightness.
module seg_scan_pwm
   import seg_scan_pkg::*;
(
   input  logic       clk,
   input  logic       reset_n,
   input  logic       clear,
   input  logic [3:0] brightness,
   output logic       lit
);

   logic [3:0] pwm_cnt_q;
   logic [3:0] pwm_cnt_d;

   // lit is evaluated on the count being loaded, so it lines up with the
   // registered segment output of the same cycle.
   always_comb begin
      pwm_cnt_d = clear ? 4'd0 : pwm_cnt_q + 4'd1;
      lit       = (brightness == BRIGHT_FULL) || (pwm_cnt_d < brightness);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         pwm_cnt_q <= 4'd0;
      end else begin
         pwm_cnt_q <= pwm_cnt_d;
      end
   end

endmodule

// File: rtl/seg_scan_driver.sv
// Time-multiplexed seven-segment scan driver with blanking, PWM and per-frame snapshot.
//
// state | meaning
// IDLE  | display dark, digit index held at 0
// BLANK | all outputs off for BLANK_CYCLES at start of a digit slot
// DRIVE | digit idx enabled, segments from shadow gated by PWM
module seg_scan_driver
   import seg_scan_pkg::*;
#(
   parameter int unsigned NUM_DIGITS     = 4,
   parameter int unsigned SCAN_DIV       = 50000,
   parameter int unsigned BLANK_CYCLES   = 500,
   parameter bit          SEG_ACTIVE_LOW = 1'b1,
   parameter bit          DIG_ACTIVE_LOW = 1'b1
) (
   input  logic               clk,
   input  logic               reset_n,
   seg_scan_driver_if.slave   bus
);

   localparam int unsigned CNT_W = $clog2(SCAN_DIV);
   localparam int unsigned IDX_W = $clog2(NUM_DIGITS);

   localparam logic [CNT_W-1:0] BLANK_LOAD = CNT_W'(BLANK_CYCLES - 1);
   localparam logic [CNT_W-1:0] DRIVE_LOAD = CNT_W'(SCAN_DIV - BLANK_CYCLES - 1);
   localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(NUM_DIGITS - 1);

   localparam logic [7:0]            SEG_OFF     = seg_off(SEG_ACTIVE_LOW);
   localparam logic [MAX_DIGITS-1:0] DIG_OFF_ALL = dig_off(DIG_ACTIVE_LOW);
   localparam logic [NUM_DIGITS-1:0] DIG_OFF     = DIG_OFF_ALL[NUM_DIGITS-1:0];

   state_e                          state_q, state_d;
   logic [CNT_W-1:0]                cnt_q, cnt_d;
   logic [IDX_W-1:0]                idx_q, idx_d;
   logic [NUM_DIGITS-1:0][7:0]      shadow_q, shadow_d;
   logic [7:0]                      seg_out_q, seg_out_d;
   logic [NUM_DIGITS-1:0]           dig_out_q, dig_out_d;
   logic                            frame_tick_q, frame_tick_d;
   logic                            pwm_clear;
   logic                            pwm_lit;
   logic [7:0]                      seg_log;
   logic [NUM_DIGITS-1:0]           dig_log;

   // Slot timer is a down-counter; terminal count 0 ends the phase.
   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      idx_d        = idx_q;
      shadow_d     = shadow_q;
      frame_tick_d = 1'b0;
      if (!bus.enable) begin
         state_d = IDLE;
         cnt_d   = '0;
         idx_d   = '0;
      end else begin
         case (state_q)
            IDLE: begin
               state_d      = BLANK;
               cnt_d        = BLANK_LOAD;
               idx_d        = '0;
               frame_tick_d = 1'b1;
               shadow_d     = bus.seg_in;
            end
            BLANK: begin
               if (cnt_q == '0) begin
                  state_d = DRIVE;
                  cnt_d   = DRIVE_LOAD;
               end else begin
                  cnt_d = cnt_q - CNT_W'(1);
               end
            end
            DRIVE: begin
               if (cnt_q == '0) begin
                  state_d = BLANK;
                  cnt_d   = BLANK_LOAD;
                  if (idx_q == LAST_IDX) begin
                     idx_d        = '0;
                     frame_tick_d = 1'b1;
                     shadow_d     = bus.seg_in;
                  end else begin
                     idx_d = idx_q + IDX_W'(1);
                  end
               end else begin
                  cnt_d = cnt_q - CNT_W'(1);
               end
            end
            default: begin
               state_d = IDLE;
               cnt_d   = '0;
               idx_d   = '0;
            end
         endcase
      end
   end

   assign pwm_clear = (state_d == DRIVE) && (state_q != DRIVE);

   seg_scan_pwm u_pwm (
      .clk        (clk),
      .reset_n    (reset_n),
      .clear      (pwm_clear),
      .brightness (bus.brightness),
      .lit        (pwm_lit)
   );

   // Outputs are computed from next-state values so the pins change together with the state.
   always_comb begin
      seg_log = '0;
      dig_log = '0;
      if (state_d == DRIVE) begin
         dig_log[idx_d] = 1'b1;
         if (pwm_lit) begin
            seg_log = shadow_d[idx_d];
         end
      end
      seg_out_d = seg_log ^ SEG_OFF;
      dig_out_d = dig_log ^ DIG_OFF;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q      <= IDLE;
         cnt_q        <= '0;
         idx_q        <= '0;
         shadow_q     <= '0;
         seg_out_q    <= SEG_OFF;
         dig_out_q    <= DIG_OFF;
         frame_tick_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         idx_q        <= idx_d;
         shadow_q     <= shadow_d;
         seg_out_q    <= seg_out_d;
         dig_out_q    <= dig_out_d;
         frame_tick_q <= frame_tick_d;
      end
   end

   assign bus.seg_out    = seg_out_q;
   assign bus.dig_out    = dig_out_q;
   assign bus.frame_tick = frame_tick_q;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Self-checking bench for seg_scan_driver: vector table, directed corners, random vs. frame-position model.
module tb_seg_scan_driver;
   import seg_scan_pkg::*;

   localparam int ND    = 4;
   localparam int SD    = 16;
   localparam int BC    = 2;
   localparam int FRAME = ND * SD;
   localparam logic [7:0] ALL_SEG = 8'hFF ^ (8'h01 << SEG_DP);

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   always #5 clk = ~clk;

   seg_scan_driver_if #(.NUM_DIGITS(ND)) bus ();

   seg_scan_driver #(
      .NUM_DIGITS     (ND),
      .SCAN_DIV       (SD),
      .BLANK_CYCLES   (BC),
      .SEG_ACTIVE_LOW (1'b1),
      .DIG_ACTIVE_LOW (1'b1)
   ) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   int n_cmp = 0;
   int n_bad = 0;
   int cyc   = 0;
   bit chk_on = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s at cycle %0d: got %0h, want %0h", name, cyc, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      @(negedge clk);
      cyc++;
   endtask

   task automatic wait_tick(input string name);
      int n;
      n = 0;
      do begin
         step();
         n++;
      end while (!bus.frame_tick && n < 200);
      chk(name, bus.frame_tick, 1);
   endtask

   // Reference model: position within the frame decides everything.
   bit          m_active = 1'b0;
   int          m_t = 0;
   int          m_slot, m_pos, m_pwm;
   logic [31:0] m_snap = '0;
   logic [7:0]  exp_seg = 8'hFF;
   logic [3:0]  exp_dig = 4'hF;
   logic        exp_tick = 1'b0;

   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         m_active = 1'b0;
         m_t      = 0;
         m_snap   = '0;
         exp_seg  = 8'hFF;
         exp_dig  = 4'hF;
         exp_tick = 1'b0;
      end else begin
         exp_tick = 1'b0;
         if (!bus.enable) begin
            m_active = 1'b0;
         end else if (!m_active || m_t == FRAME - 1) begin
            m_active = 1'b1;
            m_t      = 0;
            m_snap   = bus.seg_in;
            exp_tick = 1'b1;
         end else begin
            m_t++;
         end
         exp_seg = 8'hFF;
         exp_dig = 4'hF;
         if (m_active) begin
            m_slot = m_t / SD;
            m_pos  = m_t % SD;
            if (m_pos >= BC) begin
               exp_dig = ~(4'b0001 << m_slot);
               m_pwm   = m_pos - BC;
               if (bus.brightness == 4'd15 || m_pwm < int'(bus.brightness))
                  exp_seg = ~m_snap[m_slot*8 +: 8];
            end
         end
      end
   end

   logic [3:0] dig_l;
   logic [3:0] prev_l = 4'h0;
   int         off_run = 100;

   always @(negedge clk) begin
      if (chk_on) begin
         chk("model_seg", bus.seg_out, exp_seg);
         chk("model_dig", bus.dig_out, exp_dig);
         chk("model_tick", bus.frame_tick, exp_tick);
         dig_l = ~bus.dig_out;
         chk("onehot", $countones(dig_l) <= 1, 1);
         if (dig_l != 4'h0) begin
            if (prev_l == 4'h0) chk("blank_gap", off_run >= BC, 1);
            else                chk("no_direct_switch", prev_l == dig_l, 1);
            off_run = 0;
         end else begin
            off_run++;
         end
         prev_l = dig_l;
      end
   end

   typedef struct {
      int          cyc;
      bit          chg;
      logic [31:0] seg_new;
      logic [3:0]  dig;
      logic [7:0]  seg;
      logic        tick;
   } vec_t;

   vec_t vec[16];

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int on_cnt;

      vec[0]  = '{1,  1'b0, 32'h0, 4'hF, 8'hFF, 1'b1};
      vec[1]  = '{2,  1'b0, 32'h0, 4'hF, 8'hFF, 1'b0};
      vec[2]  = '{3,  1'b0, 32'h0, 4'hE, 8'hC0, 1'b0};
      vec[3]  = '{16, 1'b0, 32'h0, 4'hE, 8'hC0, 1'b0};
      vec[4]  = '{17, 1'b0, 32'h0, 4'hF, 8'hFF, 1'b0};
      vec[5]  = '{18, 1'b0, 32'h0, 4'hF, 8'hFF, 1'b0};
      vec[6]  = '{19, 1'b0, 32'h0, 4'hD, 8'hB0, 1'b0};
      vec[7]  = '{20, 1'b1, {4{ALL_SEG}}, 4'hD, 8'hB0, 1'b0};
      vec[8]  = '{32, 1'b0, 32'h0, 4'hD, 8'hB0, 1'b0};
      vec[9]  = '{35, 1'b0, 32'h0, 4'hB, 8'hA4, 1'b0};
      vec[10] = '{51, 1'b0, 32'h0, 4'h7, 8'hF9, 1'b0};
      vec[11] = '{64, 1'b0, 32'h0, 4'h7, 8'hF9, 1'b0};
      vec[12] = '{65, 1'b0, 32'h0, 4'hF, 8'hFF, 1'b1};
      vec[13] = '{66, 1'b0, 32'h0, 4'hF, 8'hFF, 1'b0};
      vec[14] = '{67, 1'b0, 32'h0, 4'hE, 8'h80, 1'b0};
      vec[15] = '{83, 1'b0, 32'h0, 4'hD, 8'h80, 1'b0};

      bus.enable     = 1'b0;
      bus.seg_in     = '0;
      bus.brightness = 4'd0;
      repeat (3) @(negedge clk);
      chk("rst_seg", bus.seg_out, 8'hFF);
      chk("rst_dig", bus.dig_out, 4'hF);
      chk("rst_tick", bus.frame_tick, 0);

      bus.enable     = 1'b1;
      bus.seg_in     = 32'h065B4F3F;
      bus.brightness = 4'd15;
      repeat (2) @(negedge clk);
      chk("rst_hold_dig", bus.dig_out, 4'hF);
      chk("rst_hold_tick", bus.frame_tick, 0);

      reset_n = 1'b1;
      cyc     = 0;
      chk_on  = 1'b1;

      for (int i = 0; i < 16; i++) begin
         while (cyc < vec[i].cyc) step();
         chk("vec_dig", bus.dig_out, vec[i].dig);
         chk("vec_seg", bus.seg_out, vec[i].seg);
         chk("vec_tick", bus.frame_tick, vec[i].tick);
         if (vec[i].chg) bus.seg_in = vec[i].seg_new;
      end

      // brightness 4: lit for the first four DRIVE cycles only
      bus.brightness = 4'd4;
      wait_tick("pwm4_tick");
      step();
      chk("pwm4_blank_dig", bus.dig_out, 4'hF);
      for (int k = 0; k < SD - BC; k++) begin
         step();
         chk("pwm4_seg", bus.seg_out, (k < 4) ? 8'h80 : 8'hFF);
         chk("pwm4_dig", bus.dig_out, 4'hE);
      end

      // brightness 0: dark segments, digits still scan, frame period unchanged
      bus.brightness = 4'd0;
      wait_tick("br0_tick");
      on_cnt = 0;
      for (int i = 1; i <= FRAME; i++) begin
         step();
         if (i < FRAME) begin
            chk("br0_seg", bus.seg_out, 8'hFF);
            if (bus.dig_out != 4'hF) on_cnt++;
         end
      end
      chk("br0_period", bus.frame_tick, 1);
      chk("br0_scan_cycles", on_cnt, ND * (SD - BC));

      // enable dropped mid digit-2 DRIVE, raised 5 cycles later
      bus.brightness = 4'd15;
      wait_tick("drop_tick");
      repeat (40) step();
      chk("drop_pre_dig", bus.dig_out, 4'hB);
      bus.enable = 1'b0;
      bus.seg_in = 32'h12345678;
      step();
      chk("drop_dig", bus.dig_out, 4'hF);
      chk("drop_seg", bus.seg_out, 8'hFF);
      chk("drop_tick", bus.frame_tick, 0);
      repeat (4) step();
      bus.enable = 1'b1;
      step();
      chk("restart_tick", bus.frame_tick, 1);
      chk("restart_blank", bus.dig_out, 4'hF);
      repeat (2) step();
      chk("restart_dig", bus.dig_out, 4'hE);
      chk("restart_seg", bus.seg_out, 8'h87);

      // enable 1->0->1 on consecutive cycles
      bus.enable = 1'b0;
      step();
      chk("toggle_idle_dig", bus.dig_out, 4'hF);
      chk("toggle_idle_tick", bus.frame_tick, 0);
      bus.enable = 1'b1;
      step();
      chk("toggle_tick", bus.frame_tick, 1);
      repeat (2) step();
      chk("toggle_dig", bus.dig_out, 4'hE);

      // asynchronous reset mid-DRIVE
      #2;
      reset_n = 1'b0;
      #1;
      chk("async_seg", bus.seg_out, 8'hFF);
      chk("async_dig", bus.dig_out, 4'hF);
      chk("async_tick", bus.frame_tick, 0);
      @(negedge clk);
      reset_n = 1'b1;
      cyc = 0;
      step();
      chk("async_restart_tick", bus.frame_tick, 1);

      // randomized run against the model
      for (int i = 0; i < 1500; i++) begin
         bus.brightness = 4'($urandom_range(0, 15));
         if ($urandom_range(0, 39) == 0) bus.seg_in = $urandom;
         bus.enable = ($urandom_range(0, 99) != 0);
         step();
      end

      chk_on = 1'b0;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
